pkt_ts_extract: RTL and testbench
=================================

// Module: pkt_ts_extract
// PURPOSE
//  Receive-side stage directly downstream of the packet insertion stage. Buffers 139-bit packet words plus
//  a per-packet valid flag, forwards valid packets unchanged, drops invalid ones. Tags packets
//  (word0[31:16]=0x0800, word0[15:0]=1 experiment, 2 reference), extracts TS/ID from word1 and reports
//  one-way latency, packet counts and ID-gap loss.
// PARAMETERS
//  PKT_DEPTH   256   input packet-word FIFO depth (usedw 8 bits)
//  VLD_DEPTH   64    input valid-flag FIFO depth
//  OUT_AFULL   161   start a packet only when out_pkt_usedw <= OUT_AFULL
// PORTS
//  clk             in   1    single clock
//  reset           in   1    synchronous, active-high
//  in_pkt_wrreq    in   1    write one packet word
//  in_pkt          in   139  [138:136] 101 head/100 mid/110 tail/111 head+tail; [135:132] bytes-1; [127:0] data
//  in_pkt_usedw    out  8    input word-FIFO fill level
//  in_valid_wrreq  in   1    write per-packet flag, after the packet's tail word
//  in_valid        in   1    1 = forward, 0 = drop
//  out_pkt_wrreq   out  1    output word strobe
//  out_pkt         out  139  output word, bit-identical to input word
//  out_pkt_usedw   in   8    downstream FIFO fill level
//  out_valid_wrreq out  1    pulses with output tail word
//  out_valid       out  1    always 1 when out_valid_wrreq
//  timer           in   32   free-running local timestamp
//  result_wrreq    out  1    one-cycle pulse per tagged packet
//  result          out  64   [63:48] pkt_id, [47:46] 01 exp / 10 ref, [45:32] 0, [31:0] latency
//  exp_cnt/ref_cnt out  32   tagged packets forwarded, per type
//  lost_cnt        out  32   accumulated missing IDs
//  max_latency     out  32   see CONFIGURATION
// BEHAVIOUR
//  Internal FIFOs: show-ahead; rdreq pops the current q. Synchronous clear on reset. Writes to a full FIFO are dropped.
//  Reset: all outputs, counters and capture registers 0; FSM IDLE; first_seen=0. Reset mid-packet discards the partial packet.
//  FSM IDLE: out_pkt_wrreq=0, out_valid_wrreq=0, result_wrreq=0.
//   - If out_pkt_usedw<=OUT_AFULL and the valid FIFO is non-empty: pop valid; q=1 -> FWD, q=0 -> DISCARD.
//   - Otherwise stay in IDLE. Backpressure is checked only here; a started packet is never stalled.
//  FSM FWD: each cycle pop one word and write it out 1 cycle later (out_pkt_wrreq=1); word index idx from 0.
//   - idx0: latch type = exp/ref/none from ethertype and [15:0].
//   - idx1: latch ts=[47:16], id=[15:0].
//   - Tail (110, or 111 at idx0): out_valid_wrreq=out_valid=1 with the tail word; then IDLE.
//   - A 1-word packet is never tagged.
//   - Tagged packet with idx>=1 at tail: result_wrreq pulses with the tail word.
//     Latency = timer - ts, mod 2^32; timer is sampled on the pop cycle of the tail word.
//   - Loss check (both types share one ID space): if first_seen and id != last_id+1, lost_cnt += (id-last_id-1) mod 2^16.
//     Then last_id=id, first_seen=1. A duplicate ID adds 65535: defined, not special-cased.
//   - exp_cnt/ref_cnt increment on their result pulse; all counters wrap at 2^32.
//  FSM DISCARD: pop words until tail 110/111 inclusive, no output; then IDLE.
//  Empty word FIFO in FWD/DISCARD: no pop, no write; wait (upstream protocol violation, hold state).
//  Back-to-back: IDLE costs 1 cycle between packets; throughput = N+1 cycles per N-word packet.
// CONFIGURATION
//  PKT_TS_MAXLAT_EN defined:
//   - max_latency tracks the largest latency reported (unsigned compare).
//   - Updates in the cycle after result_wrreq; cleared only by reset.
//  Not defined: max_latency tied to 0; comparator and register absent. All other behaviour identical.
// TESTING
//  1. Exp pkt, 4 words: ts=0x100, id=5, in_valid=1; timer=0x150 at tail -> 4 identical out words,
//     out_valid pulse on word 4, result={5,01,0,0x50}, exp_cnt=1.
//  2. Same pkt, in_valid=0 -> no out_pkt_wrreq, no result, counters unchanged; next valid pkt forwards normally.
//  3. IDs 5,6,9 then ref pkt id 10 -> lost_cnt=2, ref_cnt=1, result[47:46]=10 on last.
//  4. ts=0xFFFFFFF0, timer=0x10 -> latency 0x20; with PKT_TS_MAXLAT_EN, max_latency=0x20 after prior 0x10.
//  5. out_pkt_usedw=162 with a pkt queued -> no read; drop to 161 -> pkt starts next cycle.
//  6. Non-IP 3-word pkt and 1-word 111 pkt -> forwarded verbatim, no result; reset asserted at word 2 -> outputs 0, FIFOs empty.

Source files
------------

// File: rtl/pkt_ts_extract_if.sv
// Packet-word bus with a per-packet valid flag, as used between the receive-side pipeline stages.
// The master drives words and flags; the slave reports its fill level back.
interface pkt_ts_extract_if;
    logic         pkt_wrreq;
    logic [138:0] pkt;
    logic [7:0]   pkt_usedw;
    logic         valid_wrreq;
    logic         valid;

    modport master (
        output pkt_wrreq,
        output pkt,
        output valid_wrreq,
        output valid,
        input  pkt_usedw
    );

    modport slave (
        input  pkt_wrreq,
        input  pkt,
        input  valid_wrreq,
        input  valid,
        output pkt_usedw
    );
endinterface

// File: rtl/pkt_ts_extract.sv
// Receive-side timestamp extractor: forwards valid packets, drops invalid ones, reports latency and ID loss.
// Optional max-latency tracking is built when PKT_TS_MAXLAT_EN is defined.
module pkt_ts_extract_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = wrreq && (count != FULL_CNT);
    assign rd_en = rdreq && (count != '0);
    assign q     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module pkt_ts_extract #(
    parameter int unsigned PKT_DEPTH = 256,
    parameter int unsigned VLD_DEPTH = 64,
    parameter int unsigned OUT_AFULL = 161
) (
    input  logic                  clk,
    input  logic                  reset,
    pkt_ts_extract_if.slave       ingress,
    pkt_ts_extract_if.master      egress,
    input  logic [31:0]           timer,
    output logic                  result_wrreq,
    output logic [63:0]           result,
    output logic [31:0]           exp_cnt,
    output logic [31:0]           ref_cnt,
    output logic [31:0]           lost_cnt,
    output logic [31:0]           max_latency
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FWD,
        S_DISCARD
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_EXP  = 2'b01,
        TAG_REF  = 2'b10
    } tag_t;

    localparam int unsigned PAW = $clog2(PKT_DEPTH);
    localparam int unsigned VAW = $clog2(VLD_DEPTH);

    state_t state;
    state_t state_next;

    logic [138:0] word_q;
    logic [PAW:0] word_count;
    logic         word_empty;
    logic         word_rd;
    logic         vld_q;
    logic [VAW:0] vld_count;
    logic         vld_empty;
    logic         vld_rd;

    logic [2:0]   word_hdr;
    logic         word_tail;
    tag_t         word_tag;
    logic         fwd_pop;

    logic [1:0]   idx;
    tag_t         tag_r;
    logic [31:0]  ts_r;
    logic [15:0]  id_r;
    logic [15:0]  last_id;
    logic         first_seen;
    logic [31:0]  cur_ts;
    logic [15:0]  cur_id;
    logic [15:0]  id_gap;
    logic         id_break;
    logic         tagged_tail;

    logic         out_wrreq_r;
    logic [138:0] out_pkt_r;
    logic         out_vwr_r;

    pkt_ts_extract_fifo #(
        .WIDTH (139),
        .DEPTH (PKT_DEPTH)
    ) u_word_fifo (
        .clk   (clk),
        .reset (reset),
        .wrreq (ingress.pkt_wrreq),
        .data  (ingress.pkt),
        .rdreq (word_rd),
        .q     (word_q),
        .count (word_count)
    );

    pkt_ts_extract_fifo #(
        .WIDTH (1),
        .DEPTH (VLD_DEPTH)
    ) u_vld_fifo (
        .clk   (clk),
        .reset (reset),
        .wrreq (ingress.valid_wrreq),
        .data  (ingress.valid),
        .rdreq (vld_rd),
        .q     (vld_q),
        .count (vld_count)
    );

    // Full word FIFO reads back as 0 on the 8-bit usedw, matching the upstream FIFO convention.
    assign ingress.pkt_usedw = 8'(word_count);
    assign word_empty        = (word_count == '0);
    assign vld_empty         = (vld_count == '0);

    assign word_hdr  = word_q[138:136];
    assign word_tail = (word_hdr == 3'b110) || (word_hdr == 3'b111);
    assign fwd_pop   = (state == S_FWD) && word_rd;

    always_comb begin
        word_tag = TAG_NONE;
        if (word_q[31:16] == 16'h0800) begin
            if (word_q[15:0] == 16'd1) begin
                word_tag = TAG_EXP;
            end else if (word_q[15:0] == 16'd2) begin
                word_tag = TAG_REF;
            end
        end
    end

    // A 2-word packet pops its TS/ID word as the tail, so bypass the capture registers.
    assign cur_ts      = (idx == 2'd1) ? word_q[47:16] : ts_r;
    assign cur_id      = (idx == 2'd1) ? word_q[15:0]  : id_r;
    assign id_gap      = cur_id - last_id - 16'd1;
    assign id_break    = first_seen && (cur_id != last_id + 16'd1);
    assign tagged_tail = fwd_pop && word_tail && (idx != 2'd0) && (tag_r != TAG_NONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        vld_rd     = 1'b0;
        word_rd    = 1'b0;
        case (state)
            S_IDLE: begin
                if (({24'b0, egress.pkt_usedw} <= OUT_AFULL) && !vld_empty) begin
                    vld_rd     = 1'b1;
                    state_next = vld_q ? S_FWD : S_DISCARD;
                end
            end
            S_FWD, S_DISCARD: begin
                if (!word_empty) begin
                    word_rd = 1'b1;
                    if (word_tail) begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wrreq_r  <= 1'b0;
            out_pkt_r    <= '0;
            out_vwr_r    <= 1'b0;
            result_wrreq <= 1'b0;
            result       <= '0;
            exp_cnt      <= '0;
            ref_cnt      <= '0;
            lost_cnt     <= '0;
            idx          <= '0;
            tag_r        <= TAG_NONE;
            ts_r         <= '0;
            id_r         <= '0;
            last_id      <= '0;
            first_seen   <= 1'b0;
        end else begin
            out_wrreq_r  <= fwd_pop;
            out_vwr_r    <= fwd_pop && word_tail;
            result_wrreq <= tagged_tail;
            if (state == S_IDLE) begin
                idx <= '0;
            end
            if (fwd_pop) begin
                out_pkt_r <= word_q;
                if (idx != 2'd2) begin
                    idx <= idx + 2'd1;
                end
                if (idx == 2'd0) begin
                    tag_r <= word_tag;
                end
                if (idx == 2'd1) begin
                    ts_r <= word_q[47:16];
                    id_r <= word_q[15:0];
                end
            end
            if (tagged_tail) begin
                result     <= {cur_id, tag_r, 14'b0, timer - cur_ts};
                last_id    <= cur_id;
                first_seen <= 1'b1;
                if (id_break) begin
                    lost_cnt <= lost_cnt + {16'b0, id_gap};
                end
                if (tag_r == TAG_EXP) begin
                    exp_cnt <= exp_cnt + 32'd1;
                end else begin
                    ref_cnt <= ref_cnt + 32'd1;
                end
            end
        end
    end

    assign egress.pkt_wrreq   = out_wrreq_r;
    assign egress.pkt         = out_pkt_r;
    assign egress.valid_wrreq = out_vwr_r;
    assign egress.valid       = out_vwr_r;

`ifdef PKT_TS_MAXLAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            max_latency <= '0;
        end else if (result_wrreq && (result[31:0] > max_latency)) begin
            max_latency <= result[31:0];
        end
    end
`else
    assign max_latency = '0;
`endif
endmodule

// File: tb/tb_pkt_ts_extract.sv
// Directed self-checking bench for pkt_ts_extract: forwarding, drop, tagging, loss, backpressure, reset.
module tb_pkt_ts_extract;
`ifdef PKT_TS_MAXLAT_EN
    localparam bit MAXLAT = 1'b1;
`else
    localparam bit MAXLAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] timer_v;
    logic        result_wrreq;
    logic [63:0] result;
    logic [31:0] exp_cnt;
    logic [31:0] ref_cnt;
    logic [31:0] lost_cnt;
    logic [31:0] max_latency;

    int n_cmp = 0;
    int n_err = 0;

    logic [139:0] got_q[$];
    logic [139:0] exp_q[$];
    logic [63:0]  res_q[$];
    logic         res_tail_q[$];

    always #5 clk = ~clk;

    pkt_ts_extract_if rx();
    pkt_ts_extract_if tx();

    pkt_ts_extract #(
        .OUT_AFULL (161)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ingress      (rx),
        .egress       (tx),
        .timer        (timer_v),
        .result_wrreq (result_wrreq),
        .result       (result),
        .exp_cnt      (exp_cnt),
        .ref_cnt      (ref_cnt),
        .lost_cnt     (lost_cnt),
        .max_latency  (max_latency)
    );

    always @(posedge clk) begin
        #2;
        if (tx.pkt_wrreq === 1'b1) got_q.push_back({tx.valid_wrreq & tx.valid, tx.pkt});
        if (result_wrreq === 1'b1) begin
            res_q.push_back(result);
            res_tail_q.push_back(tx.valid_wrreq);
        end
    end

    task automatic chk(input string tag, input logic [139:0] obs, input logic [139:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [138:0] mk_word(input int k, input int n, input logic [31:0] lo,
                                             input logic [31:0] ts, input logic [15:0] id);
        logic [138:0] w;
        w = '0;
        if (n == 1)          w[138:136] = 3'b111;
        else if (k == 0)     w[138:136] = 3'b101;
        else if (k == n - 1) w[138:136] = 3'b110;
        else                 w[138:136] = 3'b100;
        w[135:132] = 4'hF;
        w[127:96]  = {16'hC0DE, 8'(k), 8'(n)};
        w[95:48]   = 48'h1234_5678_9ABC;
        if (k == 0)      w[47:0] = {16'hBEEF, lo};
        else if (k == 1) w[47:0] = {ts, id};
        else             w[47:0] = {32'(k) * 32'h0101_0101, 16'(k)};
        return w;
    endfunction

    task automatic push_pkt(input int n, input logic [31:0] lo, input logic [31:0] ts,
                            input logic [15:0] id, input logic vld);
        logic [138:0] w;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w = mk_word(k, n, lo, ts, id);
            rx.pkt_wrreq = 1'b1;
            rx.pkt = w;
            if (vld) exp_q.push_back({1'(k == n - 1), w});
        end
        @(negedge clk);
        rx.pkt_wrreq = 1'b0;
        rx.valid_wrreq = 1'b1;
        rx.valid = vld;
        @(negedge clk);
        rx.valid_wrreq = 1'b0;
        rx.valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_nwords"}, 140'(got_q.size()), 140'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_res(input string tag, input int n_exp, input logic [63:0] exp_last);
        chk({tag, "_nres"}, 140'(res_q.size()), 140'(n_exp));
        if (n_exp > 0) begin
            chk({tag, "_result"}, 140'((res_q.size() > 0) ? res_q[$] : 64'hx), 140'(exp_last));
            chk({tag, "_res_with_tail"}, 140'((res_tail_q.size() > 0) ? res_tail_q[$] : 1'bx), 140'(1'b1));
        end
        res_q.delete();
        res_tail_q.delete();
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] e, input logic [31:0] r,
                             input logic [31:0] l, input logic [31:0] m);
        chk({tag, "_exp_cnt"}, 140'(exp_cnt), 140'(e));
        chk({tag, "_ref_cnt"}, 140'(ref_cnt), 140'(r));
        chk({tag, "_lost_cnt"}, 140'(lost_cnt), 140'(l));
        chk({tag, "_max_lat"}, 140'(max_latency), 140'(MAXLAT ? m : 32'd0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        res_q.delete();
        res_tail_q.delete();
    endtask

    initial begin
        rx.pkt_wrreq = 1'b0;
        rx.pkt = '0;
        rx.valid_wrreq = 1'b0;
        rx.valid = 1'b0;
        tx.pkt_usedw = 8'd0;
        timer_v = 32'd0;

        do_reset();
        chk("rst_out_wrreq", 140'(tx.pkt_wrreq), 140'(1'b0));
        chk("rst_out_vwrreq", 140'(tx.valid_wrreq), 140'(1'b0));
        chk("rst_res_wrreq", 140'(result_wrreq), 140'(1'b0));
        chk("rst_result", 140'(result), 140'(64'd0));
        chk("rst_in_usedw", 140'(rx.pkt_usedw), 140'(8'd0));
        check_cnt("rst", 32'd0, 32'd0, 32'd0, 32'd0);

        // Basic experiment packet.
        timer_v = 32'h150;
        push_pkt(4, 32'h0800_0001, 32'h100, 16'd5, 1'b1);
        wait_cyc(15);
        check_out("t1");
        check_res("t1", 1, 64'h0005_4000_0000_0050);
        check_cnt("t1", 32'd1, 32'd0, 32'd0, 32'h50);

        // Dropped packet, then a normal one.
        push_pkt(4, 32'h0800_0001, 32'h100, 16'd5, 1'b0);
        wait_cyc(15);
        check_out("t2_drop");
        check_res("t2_drop", 0, 64'd0);
        check_cnt("t2_drop", 32'd1, 32'd0, 32'd0, 32'h50);
        push_pkt(4, 32'h0800_0001, 32'h100, 16'd6, 1'b1);
        wait_cyc(15);
        check_out("t2_next");
        check_res("t2_next", 1, 64'h0006_4000_0000_0050);
        check_cnt("t2_next", 32'd2, 32'd0, 32'd0, 32'h50);

        // ID gap, reference packet, duplicate ID.
        timer_v = 32'h250;
        push_pkt(3, 32'h0800_0001, 32'h200, 16'd9, 1'b1);
        wait_cyc(15);
        check_out("t3_gap");
        check_res("t3_gap", 1, 64'h0009_4000_0000_0050);
        check_cnt("t3_gap", 32'd3, 32'd0, 32'd2, 32'h50);
        timer_v = 32'h350;
        push_pkt(4, 32'h0800_0002, 32'h300, 16'd10, 1'b1);
        wait_cyc(15);
        check_out("t3_ref");
        check_res("t3_ref", 1, 64'h000A_8000_0000_0050);
        check_cnt("t3_ref", 32'd3, 32'd1, 32'd2, 32'h50);
        push_pkt(2, 32'h0800_0001, 32'h300, 16'd10, 1'b1);
        wait_cyc(15);
        check_out("t3_dup");
        check_res("t3_dup", 1, 64'h000A_4000_0000_0050);
        check_cnt("t3_dup", 32'd4, 32'd1, 32'h0001_0001, 32'h50);

        do_reset();
        check_cnt("rst2", 32'd0, 32'd0, 32'd0, 32'd0);

        // Latency wrap and max tracking; 2-word packet uses the bypassed TS/ID.
        timer_v = 32'h1010;
        push_pkt(2, 32'h0800_0001, 32'h1000, 16'd11, 1'b1);
        wait_cyc(15);
        check_out("t4_a");
        check_res("t4_a", 1, 64'h000B_4000_0000_0010);
        check_cnt("t4_a", 32'd1, 32'd0, 32'd0, 32'h10);
        timer_v = 32'h10;
        push_pkt(3, 32'h0800_0001, 32'hFFFF_FFF0, 16'd12, 1'b1);
        wait_cyc(15);
        check_out("t4_wrap");
        check_res("t4_wrap", 1, 64'h000C_4000_0000_0020);
        check_cnt("t4_wrap", 32'd2, 32'd0, 32'd0, 32'h20);

        // Non-IP and single-word packets pass untagged.
        push_pkt(3, 32'h86DD_0001, 32'h0, 16'd99, 1'b1);
        push_pkt(1, 32'h0800_0001, 32'h0, 16'd0, 1'b1);
        wait_cyc(15);
        check_out("t6_untag");
        check_res("t6_untag", 0, 64'd0);
        check_cnt("t6_untag", 32'd2, 32'd0, 32'd0, 32'h20);

        // Backpressure threshold.
        @(negedge clk);
        tx.pkt_usedw = 8'd162;
        timer_v = 32'h5;
        push_pkt(4, 32'h0800_0001, 32'h0, 16'd13, 1'b1);
        wait_cyc(10);
        chk("t5_held_nwords", 140'(got_q.size()), 140'(0));
        chk("t5_in_usedw", 140'(rx.pkt_usedw), 140'(8'd4));
        tx.pkt_usedw = 8'd161;
        @(negedge clk);
        chk("t5_pop_valid", 140'(got_q.size()), 140'(0));
        @(negedge clk);
        chk("t5_first_word", 140'(got_q.size()), 140'(1));
        wait_cyc(10);
        check_out("t5");
        check_res("t5", 1, 64'h000D_4000_0000_0005);
        check_cnt("t5", 32'd3, 32'd0, 32'd0, 32'h20);

        // Reset in the middle of a forwarded packet.
        tx.pkt_usedw = 8'd162;
        push_pkt(4, 32'h0800_0001, 32'h0, 16'd14, 1'b1);
        tx.pkt_usedw = 8'd161;
        wait_cyc(3);
        chk("t6_mid_nwords", 140'(got_q.size()), 140'(2));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_out_wrreq", 140'(tx.pkt_wrreq), 140'(1'b0));
        chk("t6_rst_in_usedw", 140'(rx.pkt_usedw), 140'(8'd0));
        chk("t6_rst_result", 140'(result), 140'(64'd0));
        check_cnt("t6_rst", 32'd0, 32'd0, 32'd0, 32'd0);
        got_q.delete();
        exp_q.delete();
        res_q.delete();
        res_tail_q.delete();
        wait_cyc(10);
        chk("t6_no_residue", 140'(got_q.size()), 140'(0));
        push_pkt(2, 32'h86DD_0002, 32'h0, 16'd1, 1'b1);
        wait_cyc(15);
        check_out("t6_after");
        check_res("t6_after", 0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
